// File: rtl/dds_doppler_sweep_pkg.sv
// dds_doppler_sweep_pkg: shared state encoding, register-file config record and default widths
package dds_doppler_sweep_pkg;
  localparam int DEF_CODE_WIDTH  = 32;
  localparam int DEF_DWELL_WIDTH = 16;
  localparam int DEF_BIN_WIDTH   = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DWELL = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } state_e;
  typedef struct packed {
    logic [DEF_CODE_WIDTH-1:0]  code_start;
    logic [DEF_CODE_WIDTH-1:0]  code_step;
    logic [DEF_BIN_WIDTH-1:0]   n_bins;
    logic [DEF_DWELL_WIDTH-1:0] dwell_len;
  } cfg_t;
endpackage

// File: rtl/dds_doppler_sweep.sv
// dds_doppler_sweep: steps the acquisition DDS through a grid of Doppler bins, dwelling and dumping per bin
// Ports: clk/resetn (async active-low); start/abort control; code_start, code_step, n_bins, dwell_len config;
// dump_ready from accumulator; dds_code/dds_syn_reset/dds_en to DDS; dump, bin_idx, busy, done status.
module dds_doppler_sweep
  import dds_doppler_sweep_pkg::*;
#(
  parameter int CODE_WIDTH  = DEF_CODE_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH,
  parameter int BIN_WIDTH   = DEF_BIN_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CODE_WIDTH-1:0]  code_start,
  input  logic [CODE_WIDTH-1:0]  code_step,
  input  logic [BIN_WIDTH-1:0]   n_bins,
  input  logic [DWELL_WIDTH-1:0] dwell_len,
  input  logic                   dump_ready,
  output logic [CODE_WIDTH-1:0]  dds_code,
  output logic                   dds_syn_reset,
  output logic                   dds_en,
  output logic                   dump,
  output logic [BIN_WIDTH-1:0]   bin_idx,
  output logic                   busy,
  output logic                   done
);
  localparam logic [BIN_WIDTH-1:0]   B_ONE = 1;
  localparam logic [DWELL_WIDTH-1:0] D_ONE = 1;
  state_e                 state_q;
  logic [CODE_WIDTH-1:0]  code_q, step_q;
  logic [BIN_WIDTH-1:0]   bin_q, nbins_q;
  logic [DWELL_WIDTH-1:0] last_q, cnt_q;
  logic                   syn_q, en_q, dump_q, busy_q, done_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      code_q  <= '0;
      step_q  <= '0;
      bin_q   <= '0;
      nbins_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      syn_q   <= 1'b0;
      en_q    <= 1'b0;
      dump_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      syn_q  <= 1'b0;
      dump_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start && !abort) begin
            step_q  <= code_step;
            nbins_q <= n_bins;
            // dwell_len==0 behaves as a single-sample dwell
            last_q  <= (dwell_len == '0) ? '0 : dwell_len - D_ONE;
            busy_q  <= 1'b1;
            if (n_bins == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              bin_q   <= '0;
              code_q  <= code_start;
              syn_q   <= 1'b1;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            state_q <= DWELL;
            en_q    <= 1'b1;
            cnt_q   <= '0;
          end
          DWELL: if (cnt_q == last_q) begin
            state_q <= DUMP;
            en_q    <= 1'b0;
            dump_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + D_ONE;
          end
          DUMP: if (dump_ready) begin
            if (bin_q == nbins_q - B_ONE) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              // code only moves here, while the DDS is disabled
              bin_q   <= bin_q + B_ONE;
              code_q  <= code_q + step_q;
              syn_q   <= 1'b1;
              state_q <= LOAD;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
  assign dds_code      = code_q;
  assign dds_syn_reset = syn_q;
  assign dds_en        = en_q;
  assign dump          = dump_q;
  assign bin_idx       = bin_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_dds_doppler_sweep.sv
// tb_dds_doppler_sweep: table-driven sweeps plus directed backpressure, abort, restart and reset sequences
module tb_dds_doppler_sweep;
  import dds_doppler_sweep_pkg::*;
  typedef struct {
    cfg_t        cfg;
    int          cycles;
    int          syns;
    int          ens;
    int          dumps;
    logic [31:0] last_code;
    logic [7:0]  last_bin;
  } vec_t;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dump_ready = 1'b1;
  logic [31:0] code_start = '0;
  logic [31:0] code_step = '0;
  logic [7:0]  n_bins = '0;
  logic [15:0] dwell_len = '0;
  logic [31:0] dds_code;
  logic        dds_syn_reset, dds_en, dump, busy, done;
  logic [7:0]  bin_idx;
  int          pass = 0;
  int          total = 0;
  vec_t        vecs[5];
  always #5 clk = ~clk;
  dds_doppler_sweep dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .code_start(code_start), .code_step(code_step), .n_bins(n_bins), .dwell_len(dwell_len),
    .dump_ready(dump_ready), .dds_code(dds_code), .dds_syn_reset(dds_syn_reset), .dds_en(dds_en),
    .dump(dump), .bin_idx(bin_idx), .busy(busy), .done(done)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input cfg_t c);
    code_start = c.code_start;
    code_step  = c.code_step;
    n_bins     = c.n_bins;
    dwell_len  = c.dwell_len;
  endtask
  task automatic scramble;
    code_start = $urandom;
    code_step  = $urandom;
    n_bins     = 8'($urandom);
    dwell_len  = 16'($urandom);
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    scramble;
  endtask
  task automatic wait_done(input string nm, output int dumps);
    int k;
    k = 0;
    dumps = 0;
    while (!done && k < 400) begin
      tick;
      k++;
      if (dump) dumps++;
    end
    chk({nm, " done reached"}, done, 1'b1);
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    int k, syns, ens, dumps, run, deff;
    logic seen;
    logic [31:0] exp_code;
    syns = 0; ens = 0; dumps = 0; run = 0; seen = 1'b0;
    deff = (v.cfg.dwell_len == 16'd0) ? 1 : int'(v.cfg.dwell_len);
    drive(v.cfg);
    pulse_start;
    k = 1;
    while (!seen && k < 400) begin
      if (dds_syn_reset) syns++;
      if (dds_en) begin
        ens++;
        run++;
      end
      if (dump) begin
        exp_code = v.cfg.code_start + v.cfg.code_step * 32'(dumps);
        chk({nm, " dump bin_idx"}, bin_idx, 8'(dumps));
        chk({nm, " dump dds_code"}, dds_code, exp_code);
        chk({nm, " dwell length"}, run, deff);
        run = 0;
        dumps++;
      end
      if (done) seen = 1'b1;
      else begin
        tick;
        k++;
      end
    end
    chk({nm, " done reached"}, seen, 1'b1);
    chk({nm, " start-to-done edges"}, k, v.cycles);
    chk({nm, " syn_reset count"}, syns, v.syns);
    chk({nm, " dds_en count"}, ens, v.ens);
    chk({nm, " dump count"}, dumps, v.dumps);
    chk({nm, " final dds_code"}, dds_code, v.last_code);
    chk({nm, " final bin_idx"}, bin_idx, v.last_bin);
    chk({nm, " busy in DONE"}, busy, 1'b1);
    tick;
    chk({nm, " idle after done"}, {busy, done, dds_en, dds_syn_reset}, 4'b0000);
  endtask
  initial begin
    int k, dumps, bad;
    vecs[0] = '{cfg: '{32'h1000, 32'h0100, 8'd3, 16'd4}, cycles: 19, syns: 3, ens: 12, dumps: 3, last_code: 32'h1200, last_bin: 8'd2};
    vecs[1] = '{cfg: '{32'h10, 32'hFFFF_FFF0, 8'd3, 16'd2}, cycles: 13, syns: 3, ens: 6, dumps: 3, last_code: 32'hFFFF_FFF0, last_bin: 8'd2};
    vecs[2] = '{cfg: '{32'h1234, 32'h1, 8'd0, 16'd5}, cycles: 1, syns: 0, ens: 0, dumps: 0, last_code: 32'hFFFF_FFF0, last_bin: 8'd2};
    vecs[3] = '{cfg: '{32'hABCD_0000, 32'h1, 8'd2, 16'd0}, cycles: 7, syns: 2, ens: 2, dumps: 2, last_code: 32'hABCD_0001, last_bin: 8'd1};
    vecs[4] = '{cfg: '{32'h5, 32'h7, 8'd1, 16'd1}, cycles: 4, syns: 1, ens: 1, dumps: 1, last_code: 32'h5, last_bin: 8'd0};
    repeat (2) tick;
    chk("reset outputs", {dds_code, bin_idx, dds_syn_reset, dds_en, dump, busy, done}, '0);
    @(negedge clk);
    resetn = 1'b1;
    tick;
    chk("idle after reset", {busy, dds_en, dds_syn_reset}, 3'b000);
    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    drive('{32'h1000, 32'h0100, 8'd2, 16'd4});
    dump_ready = 1'b0;
    pulse_start;
    chk("bp first syn_reset", dds_syn_reset, 1'b1);
    k = 0;
    while (!dump && k < 50) begin
      tick;
      k++;
    end
    chk("bp dump seen", dump, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp hold in DUMP", {busy, dds_en, dds_syn_reset, dump, dds_code}, {4'b1000, 32'h1000});
    end
    dump_ready = 1'b1;
    tick;
    chk("bp resume", {dds_syn_reset, dds_en, bin_idx, dds_code}, {2'b10, 8'd1, 32'h1100});
    wait_done("bp", dumps);
    chk("bp remaining dumps", dumps, 1);
    tick;
    drive('{32'h1000, 32'h0100, 8'd3, 16'd4});
    pulse_start;
    k = 0;
    while (!(dds_en && bin_idx == 8'd1) && k < 50) begin
      tick;
      k++;
    end
    tick;
    chk("abort in bin1 dwell", {dds_en, bin_idx}, {1'b1, 8'd1});
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort outputs", {busy, dds_en, dds_syn_reset, dump, done}, 5'b00000);
    chk("abort holds bin/code", {bin_idx, dds_code}, {8'd1, 32'h1100});
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (dump || done || busy || dds_en) bad++;
    end
    chk("quiet after abort", bad, 0);
    run_vec("restart", '{cfg: '{32'h2000, 32'h10, 8'd2, 16'd1}, cycles: 7, syns: 2, ens: 2, dumps: 2, last_code: 32'h2010, last_bin: 8'd1});
    drive('{32'h4000, 32'h1, 8'd1, 16'd1});
    abort = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("abort beats start", {busy, dds_syn_reset, done}, 3'b000);
    drive('{32'h3000, 32'h0100, 8'd2, 16'd3});
    pulse_start;
    k = 0;
    while (!dds_en && k < 20) begin
      tick;
      k++;
    end
    drive('{32'h0, 32'h1, 8'd5, 16'd9});
    pulse_start;
    chk("restart ignored", {busy, dds_syn_reset, dds_code}, {2'b10, 32'h3000});
    wait_done("busy start", dumps);
    chk("busy start dumps", dumps, 2);
    chk("busy start final", {bin_idx, dds_code}, {8'd1, 32'h3100});
    tick;
    drive('{32'h7000, 32'h0100, 8'd2, 16'd6});
    pulse_start;
    k = 0;
    while (!dds_en && k < 20) begin
      tick;
      k++;
    end
    #3;
    resetn = 1'b0;
    #1;
    chk("async reset mid-dwell", {dds_code, bin_idx, dds_syn_reset, dds_en, dump, busy, done}, '0);
    @(negedge clk);
    resetn = 1'b1;
    tick;
    chk("idle after async reset", {busy, dds_en}, 2'b00);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
